arb_n_af_avlstrm: RTL

- N-input, one-output Avalon-ST arbiter with a private FIFO and almost-full flag per input.
- Round-robin arbitration with an optional packet-atomic mode (grant held from SOP to EOP).
- Tags every output beat with its source channel.
- Next-generation replacement for the fixed 2-input forwarding arbiter in the services layer: generalised channel count plus packet mode, channel tagging and a registered output.

---
 rtl/arb_n_af_avlstrm.sv | 129 ++++++++++++
 1 files changed

// File: rtl/arb_n_af_avlstrm.sv
// N-input Avalon-ST round-robin arbiter, one FIFO and almost-full flag per input.
// Optional packet-atomic grant, channel-tagged registered output.
module arb_n_af_avlstrm #(
  parameter int NUM_IN     = 4,
  parameter int DWIDTH     = 64,
  parameter int DEPTH      = 512,
  parameter int FULL_LEVEL = 400,
  parameter int PKT_MODE   = 1,
  localparam int CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NUM_IN*DWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic [NUM_IN-1:0]        in_sop,
  input  logic [NUM_IN-1:0]        in_eop,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [NUM_IN-1:0]        in_almost_full,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [CW-1:0]            out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = DWIDTH + 2;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] FULL_C  = (AW+1)'(FULL_LEVEL);

  logic [NUM_IN-1:0]    wr;
  logic [NUM_IN-1:0]    pop_v;
  logic [NUM_IN-1:0]    nonempty;
  logic [NUM_IN-1:0]    elig;
  logic [NUM_IN*FW-1:0] heads;
  logic [FW-1:0]        head;
  logic [CW-1:0]        last_grant;
  logic [CW-1:0]        grant;
  logic [CW-1:0]        idx;
  logic [CW-1:0]        lock_ch;
  logic                 lock;
  logic                 any;
  logic                 pop;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    logic [FW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_n;
    logic          rdy;
    logic          af;

    assign wr[i]       = in_valid[i] & rdy;
    assign pop_v[i]    = pop & (grant == CW'(i));
    assign nonempty[i] = (cnt != '0);
    assign elig[i]     = nonempty[i] & (!lock | (lock_ch == CW'(i)));
    assign heads[i*FW +: FW] = mem[rp];
    assign in_ready[i]       = rdy;
    assign in_almost_full[i] = af;
    assign cnt_n = cnt + {{AW{1'b0}}, wr[i]} - {{AW{1'b0}}, pop_v[i]};

    always_ff @(posedge Clk) begin
      if (wr[i])
        mem[wp] <= {in_sop[i], in_eop[i], in_data[i*DWIDTH +: DWIDTH]};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        rdy <= 1'b0;
        af  <= 1'b0;
      end else begin
        if (wr[i])    wp <= wp + 1'b1;
        if (pop_v[i]) rp <= rp + 1'b1;
        cnt <= cnt_n;
        rdy <= (cnt_n != DEPTH_C);
        // one cycle behind the count on purpose
        af  <= (cnt >= FULL_C);
      end
    end
  end

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = CW'((int'(last_grant) + k) % NUM_IN);
      if (!any && elig[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

  assign pop  = any & (!out_valid | out_ready);
  assign head = heads[grant*FW +: FW];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_chan   <= '0;
      last_grant <= CW'(NUM_IN - 1);
      lock       <= 1'b0;
      lock_ch    <= '0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_data   <= head[DWIDTH-1:0];
      out_sop    <= head[FW-1];
      out_eop    <= head[FW-2];
      out_chan   <= grant;
      last_grant <= grant;
      if (PKT_MODE != 0) begin
        lock    <= !head[FW-2];
        lock_ch <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
